// File: rtl/freelist_pkg.sv
// Helpers shared by the physical-register free list.
package freelist_pkg;

   function automatic logic [1:0] lane_cnt(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/defines.sv
// Register-file sizing shared by the rename stage: physical/logical register counts and index ranges.
`ifndef DEFINES_SV
`define DEFINES_SV
`define PREG_NUM 64
`define LREG_NUM 32
`define PREG_RANGE 5:0
`define LREG_RANGE 4:0
`endif

// File: rtl/freelist.sv
// Physical-register free list: two-wide allocate for rename, two-wide release from commit,
// speculative head restored from the architectural head on redirect. Optional checker: FREELIST_CHECK_EN.
module freelist
   import freelist_pkg::*;
#(
   parameter int PREG_NUM = `PREG_NUM,
   parameter int LREG_NUM = `LREG_NUM,
   parameter int FL_DEPTH = PREG_NUM - LREG_NUM
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      alloc_req_0,
   input  logic                      alloc_req_1,
   output logic                      alloc_ready,
   output logic [`PREG_RANGE]        alloc_preg_0,
   output logic [`PREG_RANGE]        alloc_preg_1,
   input  logic                      free_valid_0,
   input  logic [`PREG_RANGE]        free_preg_0,
   input  logic                      free_valid_1,
   input  logic [`PREG_RANGE]        free_preg_1,
   input  logic [1:0]                commit_alloc_cnt,
   input  logic                      redirect_valid,
`ifdef FREELIST_CHECK_EN
   output logic                      freelist_err,
`endif
   output logic [$clog2(FL_DEPTH):0] free_count
);

   localparam int IW = $clog2(FL_DEPTH);
   localparam int PW = IW + 1;

   typedef logic [PW-1:0]      ptr_t;
   typedef logic [IW-1:0]      idx_t;
   typedef logic [`PREG_RANGE] preg_t;

   preg_t      fl [FL_DEPTH];
   ptr_t       head, arch_head, tail;
   idx_t       head_idx, head_idx1, tail_idx, tail_idx1;
   logic [1:0] alloc_cnt, free_cnt;

   assign head_idx  = head[IW-1:0];
   assign head_idx1 = head_idx + idx_t'(1);
   assign tail_idx  = tail[IW-1:0];
   assign tail_idx1 = tail_idx + idx_t'(1);
   assign alloc_cnt = lane_cnt(alloc_req_0, alloc_req_1);
   assign free_cnt  = lane_cnt(free_valid_0, free_valid_1);

   // Ready only needs two entries, regardless of how many slots ask, to keep rename timing short.
   assign free_count   = tail - head;
   assign alloc_ready  = (free_count >= ptr_t'(2)) && !redirect_valid;
   assign alloc_preg_0 = fl[head_idx];
   assign alloc_preg_1 = alloc_req_0 ? fl[head_idx1] : fl[head_idx];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FL_DEPTH; i++) fl[i] <= preg_t'(LREG_NUM + i);
         head      <= '0;
         arch_head <= '0;
         tail      <= ptr_t'(FL_DEPTH);
      end else begin
         if (free_valid_0) fl[tail_idx] <= free_preg_0;
         if (free_valid_1) fl[free_valid_0 ? tail_idx1 : tail_idx] <= free_preg_1;
         tail      <= tail + ptr_t'(free_cnt);
         arch_head <= arch_head + ptr_t'(commit_alloc_cnt);
         // Same-cycle commit is folded into the restored head.
         if (redirect_valid)   head <= arch_head + ptr_t'(commit_alloc_cnt);
         else if (alloc_ready) head <= head + ptr_t'(alloc_cnt);
      end
   end

`ifdef FREELIST_CHECK_EN
   logic over_free, over_commit, dup_free;
   ptr_t spec_cnt;

   assign spec_cnt    = head - arch_head;
   assign over_free   = ({1'b0, free_count} + (PW+1)'(free_cnt)) > (PW+1)'(FL_DEPTH);
   assign over_commit = ptr_t'(commit_alloc_cnt) > spec_cnt;

   // An entry is live when its distance from head is below free_count.
   always_comb begin
      dup_free = 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
         if ((ptr_t'(idx_t'(i) - head_idx) < free_count) &&
             ((free_valid_0 && fl[i] == free_preg_0) || (free_valid_1 && fl[i] == free_preg_1)))
            dup_free = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                 freelist_err <= 1'b0;
      else if (over_free || over_commit || dup_free) freelist_err <= 1'b1;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (reset_n && dup_free) $error("freelist: released preg already present in free list");
   end
`endif
`endif

endmodule

// File: tb/tb_freelist.sv
// Bench for freelist: directed scenarios with literal expectations, then randomized traffic vs. a queue model.
module tb_freelist;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       alloc_req_0, alloc_req_1, alloc_ready;
   logic [5:0] alloc_preg_0, alloc_preg_1;
   logic       free_valid_0, free_valid_1;
   logic [5:0] free_preg_0, free_preg_1;
   logic [1:0] commit_alloc_cnt;
   logic       redirect_valid;
   logic [5:0] free_count;

   int checks = 0;
   int errors = 0;

   // Model: unbounded pointers, 32-slot ring, and the pool of pregs held outside the list.
   int         h, a, t;
   logic [5:0] mem [32];
   int         owned [$];

   freelist dut (
      .clock(clock), .reset_n(reset_n),
      .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1), .alloc_ready(alloc_ready),
      .alloc_preg_0(alloc_preg_0), .alloc_preg_1(alloc_preg_1),
      .free_valid_0(free_valid_0), .free_preg_0(free_preg_0),
      .free_valid_1(free_valid_1), .free_preg_1(free_preg_1),
      .commit_alloc_cnt(commit_alloc_cnt), .redirect_valid(redirect_valid),
      .free_count(free_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem[i] = 6'(32 + i);
      h = 0; a = 0; t = 32;
      owned.delete();
      for (int i = 0; i < 32; i++) owned.push_back(i);
   endtask

   task automatic take(input int p);
      for (int i = 0; i < owned.size(); i++) begin
         if (owned[i] == p) begin
            owned.delete(i);
            return;
         end
      end
   endtask

   task automatic drive_idle();
      alloc_req_0 = 0; alloc_req_1 = 0;
      free_valid_0 = 0; free_preg_0 = 0; free_valid_1 = 0; free_preg_1 = 0;
      commit_alloc_cnt = 0; redirect_valid = 0;
   endtask

   // One cycle: drive at negedge, compare against model, then advance the model.
   task automatic step(input logic r0, input logic r1, input logic f0, input logic [5:0] p0,
                       input logic f1, input logic [5:0] p1, input logic [1:0] c, input logic rd);
      int         exp_cnt, k;
      logic       exp_rdy;
      logic [5:0] e0, e1;
      @(negedge clock);
      alloc_req_0 = r0; alloc_req_1 = r1;
      free_valid_0 = f0; free_preg_0 = p0; free_valid_1 = f1; free_preg_1 = p1;
      commit_alloc_cnt = c; redirect_valid = rd;
      #1;
      exp_cnt = t - h;
      exp_rdy = (exp_cnt >= 2) && !rd;
      e0 = mem[h % 32];
      e1 = r0 ? mem[(h + 1) % 32] : e0;
      chk("free_count", 32'(free_count), 32'(exp_cnt));
      chk("alloc_ready", 32'(alloc_ready), 32'(exp_rdy));
      chk("alloc_preg_0", 32'(alloc_preg_0), 32'(e0));
      chk("alloc_preg_1", 32'(alloc_preg_1), 32'(e1));
      for (int j = 0; j < int'(c); j++) owned.push_back(int'(mem[(a + j) % 32]));
      k = t;
      if (f0) begin mem[k % 32] = p0; k++; end
      if (f1) mem[k % 32] = p1;
      t = t + int'(f0) + int'(f1);
      if (rd)           h = a + int'(c);
      else if (exp_rdy) h = h + int'(r0) + int'(r1);
      a = a + int'(c);
   endtask

   initial begin
      int         cmax, fmax, nf, c, idx;
      logic       r0, r1, rd, f0, f1;
      logic [5:0] p0, p1;

      reset_n = 0;
      drive_idle();
      model_reset();
      #12;
      chk("reset_free_count", 32'(free_count), 32);
      chk("reset_ready", 32'(alloc_ready), 1);
      chk("reset_preg_0", 32'(alloc_preg_0), 32);
      chk("reset_preg_1", 32'(alloc_preg_1), 32);
      @(negedge clock);
      reset_n = 1;

      // Sixteen double allocations hand out 32..63 in order.
      for (int k = 0; k < 16; k++) begin
         step(1, 1, 0, 0, 0, 0, 0, 0);
         chk("seq_preg_0", 32'(alloc_preg_0), 32'(32 + 2 * k));
         chk("seq_preg_1", 32'(alloc_preg_1), 32'(33 + 2 * k));
      end
      step(1, 1, 0, 0, 0, 0, 0, 0);
      chk("empty_ready", 32'(alloc_ready), 0);
      chk("empty_count", 32'(free_count), 0);

      // Drain to one entry; a single request must not fire.
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 15; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      chk("one_left_ready", 32'(alloc_ready), 0);
      chk("one_left_count", 32'(free_count), 1);
      chk("one_left_preg_1", 32'(alloc_preg_1), 63);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("one_left_hold", 32'(free_count), 1);

      // Allocate 6, commit 2, redirect.
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 2, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("redir_count", 32'(free_count), 30);
      chk("redir_preg", 32'(alloc_preg_0), 34);

      // Redirect together with a one-instruction commit.
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 1, 1);
      chk("redir_commit_block", 32'(alloc_ready), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("redir_commit_count", 32'(free_count), 29);
      chk("redir_commit_preg", 32'(alloc_preg_0), 35);

      // Release 5 and 7 at the tail, then consume around the wrap.
      take(5); take(7);
      step(0, 0, 1, 5, 1, 7, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("after_free_count", 32'(free_count), 31);
      for (int k = 0; k < 14; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      chk("wrap_preg_0", 32'(alloc_preg_0), 5);
      chk("wrap_preg_1", 32'(alloc_preg_1), 7);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("wrap_count", 32'(free_count), 0);

      // Randomized traffic within the commit/free invariants.
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            @(negedge clock);
            drive_idle();
            #2 reset_n = 0;
            #1;
            chk("midrun_reset_count", 32'(free_count), 32);
            chk("midrun_reset_preg", 32'(alloc_preg_0), 32);
            model_reset();
            @(negedge clock);
            reset_n = 1;
         end
         r0   = 1'($urandom);
         r1   = 1'($urandom);
         rd   = ($urandom % 20) == 0;
         cmax = (h - a) < 2 ? (h - a) : 2;
         c    = $urandom_range(cmax, 0);
         fmax = owned.size() - 32 + c;
         if (fmax > 2) fmax = 2;
         nf   = $urandom_range(fmax, 0);
         f0 = 0; f1 = 0; p0 = 0; p1 = 0;
         if (nf >= 1) begin
            idx = $urandom_range(owned.size() - 1, 0);
            p0 = 6'(owned[idx]);
            owned.delete(idx);
            f0 = 1;
         end
         if (nf == 2) begin
            idx = $urandom_range(owned.size() - 1, 0);
            p1 = 6'(owned[idx]);
            owned.delete(idx);
            f1 = 1;
         end else if (nf == 1 && $urandom_range(1, 0) == 1) begin
            p1 = p0; f1 = 1; p0 = 0; f0 = 0;
         end
         step(r0, r1, f0, p0, f1, p1, 2'(c), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
